regfile_scoreboard: RTL and testbench

REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

---
 rtl/regfile_scoreboard.sv | 139 +++++++++++++
 tb/tb_regfile_scoreboard.sv | 418 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_scoreboard.sv
// Register-file write scoreboard for an in-order issue stage.
//
// Keeps one small counter per architectural register. Each counter holds the
// number of issued writes to that register that have not yet written back. The
// block decides each cycle whether the instruction in decode may issue. It
// flags which sources can take the value that is writing back in the same cycle.
//
// Ports:
//   clk, rst            clock; synchronous active-low reset
//   issue_valid         decode holds an instruction requesting issue
//   rs_idx/rs_used      first source index and read enable
//   rt_idx/rt_used      second source index and read enable
//   dest_idx/dest_wr    destination index and write enable
//   wb_valid/wb_idx     register-file write happening this cycle
//   flush               kill every in-flight instruction younger than writeback
//   issue_fire/stall    instruction accepted / held this cycle
//   fwd_rs/fwd_rt       source must be taken from the writeback value
//   pending_mask        per-register "write outstanding" flags
//   busy                any write outstanding
//   stall_cnt           saturating count of stall cycles
module regfile_scoreboard #(
    parameter int unsigned NREG  = 8,
    parameter int unsigned CNT_W = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            issue_valid,
    input  logic [2:0]      rs_idx,
    input  logic [2:0]      rt_idx,
    input  logic            rs_used,
    input  logic            rt_used,
    input  logic [2:0]      dest_idx,
    input  logic            dest_wr,
    input  logic            wb_valid,
    input  logic [2:0]      wb_idx,
    input  logic            flush,
    output logic            issue_fire,
    output logic            stall,
    output logic            fwd_rs,
    output logic            fwd_rt,
    output logic [NREG-1:0] pending_mask,
    output logic            busy,
    output logic [7:0]      stall_cnt
);

    localparam int unsigned       IDX_W   = 3;
    localparam logic [CNT_W-1:0]  CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q [NREG];
    logic [CNT_W-1:0] cnt_d [NREG];
    logic [7:0]       stall_cnt_q;
    logic [7:0]       stall_cnt_d;

    logic [NREG-1:0]  wb_hit;
    logic [NREG-1:0]  inc;
    logic [NREG-1:0]  dec;

    logic [CNT_W-1:0] rs_cnt;
    logic [CNT_W-1:0] rt_cnt;
    logic [CNT_W-1:0] dest_cnt;
    logic             rs_hazard;
    logic             rt_hazard;
    logic             dest_full;
    logic             active;

    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            wb_hit[r] = wb_valid && (wb_idx == IDX_W'(r));
        end
    end

    assign rs_cnt   = cnt_q[rs_idx];
    assign rt_cnt   = cnt_q[rt_idx];
    assign dest_cnt = cnt_q[dest_idx];

    // A source with exactly one outstanding write is safe only when that write
    // lands this cycle; the value is then taken from the writeback bus.
    assign rs_hazard = rs_used &&
        ((rs_cnt > CNT_ONE) || ((rs_cnt == CNT_ONE) && !wb_hit[rs_idx]));
    assign rt_hazard = rt_used &&
        ((rt_cnt > CNT_ONE) || ((rt_cnt == CNT_ONE) && !wb_hit[rt_idx]));
    // A saturated counter may still accept a writer if a writeback frees a slot.
    assign dest_full = dest_wr && (dest_cnt == CNT_MAX) && !wb_hit[dest_idx];

    // Reset and flush both suppress every issue-side output.
    assign active     = rst && issue_valid && !flush;
    assign stall      = active && (rs_hazard || rt_hazard || dest_full);
    assign issue_fire = active && !(rs_hazard || rt_hazard || dest_full);
    assign fwd_rs     = issue_fire && rs_used && (rs_cnt == CNT_ONE) && wb_hit[rs_idx];
    assign fwd_rt     = issue_fire && rt_used && (rt_cnt == CNT_ONE) && wb_hit[rt_idx];

    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            inc[r] = issue_fire && dest_wr && (dest_idx == IDX_W'(r));
            // Writeback to an idle register is dropped rather than wrapping.
            dec[r] = wb_hit[r] && (cnt_q[r] != '0);
            cnt_d[r] = cnt_q[r];
            if (flush) begin
                cnt_d[r] = '0;
            end else if (inc[r] && !dec[r]) begin
                cnt_d[r] = cnt_q[r] + CNT_ONE;
            end else if (dec[r] && !inc[r]) begin
                cnt_d[r] = cnt_q[r] - CNT_ONE;
            end
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != 8'hFF)) begin
            stall_cnt_d = stall_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int r = 0; r < NREG; r++) begin
                cnt_q[r] <= '0;
            end
            stall_cnt_q <= 8'd0;
        end else begin
            for (int r = 0; r < NREG; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
            stall_cnt_q <= stall_cnt_d;
        end
    end

    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            pending_mask[r] = (cnt_q[r] != '0);
        end
    end

    assign busy      = |pending_mask;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard. Each scenario drives a table of
// cycles and queues the expected issue outputs. It then pops and compares
// them once the outputs settle. It also checks pending_mask, busy and
// stall_cnt after each clock edge.
module tb_regfile_scoreboard;

    logic       clk = 1'b0;
    logic       rst;
    logic       issue_valid;
    logic [2:0] rs_idx;
    logic [2:0] rt_idx;
    logic       rs_used;
    logic       rt_used;
    logic [2:0] dest_idx;
    logic       dest_wr;
    logic       wb_valid;
    logic [2:0] wb_idx;
    logic       flush;
    logic       issue_fire;
    logic       stall;
    logic       fwd_rs;
    logic       fwd_rt;
    logic [7:0] pending_mask;
    logic       busy;
    logic [7:0] stall_cnt;

    always #5 clk = ~clk;

    regfile_scoreboard #(.NREG(8), .CNT_W(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .issue_valid  (issue_valid),
        .rs_idx       (rs_idx),
        .rt_idx       (rt_idx),
        .rs_used      (rs_used),
        .rt_used      (rt_used),
        .dest_idx     (dest_idx),
        .dest_wr      (dest_wr),
        .wb_valid     (wb_valid),
        .wb_idx       (wb_idx),
        .flush        (flush),
        .issue_fire   (issue_fire),
        .stall        (stall),
        .fwd_rs       (fwd_rs),
        .fwd_rt       (fwd_rt),
        .pending_mask (pending_mask),
        .busy         (busy),
        .stall_cnt    (stall_cnt)
    );

    // One cycle of stimulus: inputs, expected {fire, stall, fwd_rs, fwd_rt},
    // and expected pending_mask after the edge.
    typedef struct {
        int       iv, rs, rsu, rt, rtu, dst, dw, wbv, wbi, fl;
        logic [3:0] out;
        int       mask;
    } step_t;

    int         errors = 0;
    int         checks = 0;
    int         exp_sc = 0;
    bit         wb_exempt = 1'b0;
    logic [3:0] exp_q [$];
    int         model_cnt [8];

    task automatic apply(input step_t s);
        issue_valid = 1'(s.iv);
        rs_idx      = 3'(s.rs);
        rs_used     = 1'(s.rsu);
        rt_idx      = 3'(s.rt);
        rt_used     = 1'(s.rtu);
        dest_idx    = 3'(s.dst);
        dest_wr     = 1'(s.dw);
        wb_valid    = 1'(s.wbv);
        wb_idx      = 3'(s.wbi);
        flush       = 1'(s.fl);
    endtask

    // Protocol monitor: issue_fire/stall exclusive, and the stimulus never
    // writes back to an idle register except where a scenario allows it.
    always begin
        @(negedge clk);
        #2;
        if (rst === 1'b1) begin
            checks++;
            if (issue_fire === 1'b1 && stall === 1'b1) begin
                errors++;
                $display("FAIL fire_stall_excl: issue_fire=%b stall=%b expected not both 1",
                         issue_fire, stall);
            end
            if (wb_valid === 1'b1 && flush !== 1'b1 && !wb_exempt) begin
                checks++;
                if (model_cnt[wb_idx] == 0) begin
                    errors++;
                    $display("FAIL wb_to_idle: wb_idx=%0d count=%0d expected nonzero",
                             wb_idx, model_cnt[wb_idx]);
                end
            end
        end
        for (int r = 0; r < 8; r++) begin
            if (rst !== 1'b1 || flush === 1'b1) begin
                model_cnt[r] = 0;
            end else begin
                automatic bit up = (issue_fire === 1'b1) && dest_wr && (dest_idx == 3'(r));
                automatic bit dn = wb_valid && (wb_idx == 3'(r)) && (model_cnt[r] > 0);
                if (up && !dn) model_cnt[r]++;
                else if (dn && !up) model_cnt[r]--;
            end
        end
    end

    task automatic test_reset();
        logic [3:0] got, want;
        rst = 1'b0;
        apply('{1, 3, 1, 5, 1, 2, 1, 1, 4, 0, 4'b0000, 0});
        exp_sc = 0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            exp_q.push_back(4'b0000);
            #1;
            got  = {issue_fire, stall, fwd_rs, fwd_rt};
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL reset_outputs: fire/stall/fwd_rs/fwd_rt=%b expected %b", got, want);
            end
            @(posedge clk);
            #1;
            checks++;
            if (pending_mask !== 8'h00 || busy !== 1'b0 || stall_cnt !== 8'd0) begin
                errors++;
                $display("FAIL reset_state: mask=%h busy=%b stall_cnt=%0d expected 00 0 0",
                         pending_mask, busy, stall_cnt);
            end
        end
        @(negedge clk);
        apply('{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 0});
        rst = 1'b1;
    endtask

    task automatic test_raw_forward();
        step_t      st [3];
        logic [3:0] got, want;
        st = '{'{1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 4'b1000, 'h08},
               '{1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 4'b0100, 'h08},
               '{1, 3, 1, 0, 0, 0, 0, 1, 3, 0, 4'b1010, 'h00}};
        foreach (st[i]) begin
            @(negedge clk);
            apply(st[i]);
            exp_q.push_back(st[i].out);
            if (st[i].out[2] && exp_sc < 255) exp_sc++;
            #1;
            got  = {issue_fire, stall, fwd_rs, fwd_rt};
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL raw_forward step %0d: fire/stall/fwd_rs/fwd_rt=%b expected %b",
                         i, got, want);
            end
            @(posedge clk);
            #1;
            checks++;
            if (pending_mask !== 8'(st[i].mask) || busy !== (st[i].mask != 0)) begin
                errors++;
                $display("FAIL raw_forward step %0d: mask=%h busy=%b expected mask %h",
                         i, pending_mask, busy, st[i].mask);
            end
            checks++;
            if (stall_cnt !== 8'(exp_sc)) begin
                errors++;
                $display("FAIL raw_forward step %0d: stall_cnt=%0d expected %0d",
                         i, stall_cnt, exp_sc);
            end
        end
    endtask

    task automatic test_dest_full();
        step_t      st [9];
        logic [3:0] got, want;
        st = '{'{1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 4'b1000, 'h20},
               '{1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 4'b1000, 'h20},
               '{1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 4'b1000, 'h20},
               '{1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 4'b0100, 'h20},
               '{1, 0, 0, 0, 0, 5, 1, 1, 5, 0, 4'b1000, 'h20},
               '{1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 4'b0100, 'h20},
               '{0, 0, 0, 0, 0, 0, 0, 1, 5, 0, 4'b0000, 'h20},
               '{1, 0, 0, 5, 1, 0, 0, 1, 5, 0, 4'b0100, 'h20},
               '{1, 0, 0, 5, 1, 0, 0, 1, 5, 0, 4'b1001, 'h00}};
        foreach (st[i]) begin
            @(negedge clk);
            apply(st[i]);
            exp_q.push_back(st[i].out);
            if (st[i].out[2] && exp_sc < 255) exp_sc++;
            #1;
            got  = {issue_fire, stall, fwd_rs, fwd_rt};
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL dest_full step %0d: fire/stall/fwd_rs/fwd_rt=%b expected %b",
                         i, got, want);
            end
            @(posedge clk);
            #1;
            checks++;
            if (pending_mask !== 8'(st[i].mask) || busy !== (st[i].mask != 0)) begin
                errors++;
                $display("FAIL dest_full step %0d: mask=%h busy=%b expected mask %h",
                         i, pending_mask, busy, st[i].mask);
            end
            checks++;
            if (stall_cnt !== 8'(exp_sc)) begin
                errors++;
                $display("FAIL dest_full step %0d: stall_cnt=%0d expected %0d",
                         i, stall_cnt, exp_sc);
            end
        end
    endtask

    // Same-cycle issue+writeback, register 0 as an ordinary register, and
    // unused sources that must not stall.
    task automatic test_same_cycle_wb();
        step_t      st [9];
        logic [3:0] got, want;
        st = '{'{1, 0, 0, 0, 0, 2, 1, 0, 0, 0, 4'b1000, 'h04},
               '{1, 0, 0, 0, 0, 2, 1, 1, 2, 0, 4'b1000, 'h04},
               '{0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 4'b0000, 'h00},
               '{1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 4'b1000, 'h01},
               '{1, 0, 1, 0, 1, 0, 0, 0, 0, 0, 4'b0100, 'h01},
               '{1, 0, 1, 0, 1, 0, 0, 1, 0, 0, 4'b1011, 'h00},
               '{1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 4'b1000, 'h02},
               '{1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 4'b1000, 'h02},
               '{0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 4'b0000, 'h00}};
        foreach (st[i]) begin
            @(negedge clk);
            apply(st[i]);
            exp_q.push_back(st[i].out);
            if (st[i].out[2] && exp_sc < 255) exp_sc++;
            #1;
            got  = {issue_fire, stall, fwd_rs, fwd_rt};
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL same_cycle_wb step %0d: fire/stall/fwd_rs/fwd_rt=%b expected %b",
                         i, got, want);
            end
            @(posedge clk);
            #1;
            checks++;
            if (pending_mask !== 8'(st[i].mask) || busy !== (st[i].mask != 0)) begin
                errors++;
                $display("FAIL same_cycle_wb step %0d: mask=%h busy=%b expected mask %h",
                         i, pending_mask, busy, st[i].mask);
            end
            checks++;
            if (stall_cnt !== 8'(exp_sc)) begin
                errors++;
                $display("FAIL same_cycle_wb step %0d: stall_cnt=%0d expected %0d",
                         i, stall_cnt, exp_sc);
            end
        end
    endtask

    task automatic test_flush();
        step_t      st [5];
        logic [3:0] got, want;
        st = '{'{1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 4'b1000, 'h02},
               '{1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 4'b1000, 'h02},
               '{1, 0, 0, 0, 0, 4, 1, 0, 0, 0, 4'b1000, 'h12},
               '{1, 1, 1, 0, 0, 4, 1, 1, 1, 1, 4'b0000, 'h00},
               '{1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 4'b1000, 'h00}};
        foreach (st[i]) begin
            @(negedge clk);
            apply(st[i]);
            exp_q.push_back(st[i].out);
            if (st[i].out[2] && exp_sc < 255) exp_sc++;
            #1;
            got  = {issue_fire, stall, fwd_rs, fwd_rt};
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL flush step %0d: fire/stall/fwd_rs/fwd_rt=%b expected %b",
                         i, got, want);
            end
            @(posedge clk);
            #1;
            checks++;
            if (pending_mask !== 8'(st[i].mask) || busy !== (st[i].mask != 0)) begin
                errors++;
                $display("FAIL flush step %0d: mask=%h busy=%b expected mask %h",
                         i, pending_mask, busy, st[i].mask);
            end
            checks++;
            if (stall_cnt !== 8'(exp_sc)) begin
                errors++;
                $display("FAIL flush step %0d: stall_cnt=%0d expected %0d",
                         i, stall_cnt, exp_sc);
            end
        end
    endtask

    task automatic test_stall_saturate();
        step_t      s;
        logic [3:0] got, want;
        for (int n = 0; n < 307; n++) begin
            if (n == 0)        s = '{1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 4'b1000, 'h80};
            else if (n < 306)  s = '{1, 7, 1, 0, 0, 0, 0, 0, 0, 0, 4'b0100, 'h80};
            else               s = '{0, 0, 0, 0, 0, 0, 0, 1, 7, 0, 4'b0000, 'h00};
            @(negedge clk);
            apply(s);
            exp_q.push_back(s.out);
            if (s.out[2] && exp_sc < 255) exp_sc++;
            #1;
            got  = {issue_fire, stall, fwd_rs, fwd_rt};
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL stall_saturate cycle %0d: fire/stall/fwd_rs/fwd_rt=%b expected %b",
                         n, got, want);
            end
            @(posedge clk);
            #1;
            checks++;
            if (stall_cnt !== 8'(exp_sc) || pending_mask !== 8'(s.mask)) begin
                errors++;
                $display("FAIL stall_saturate cycle %0d: stall_cnt=%0d mask=%h expected %0d %h",
                         n, stall_cnt, pending_mask, exp_sc, s.mask);
            end
        end
        checks++;
        if (stall_cnt !== 8'd255) begin
            errors++;
            $display("FAIL stall_saturate final: stall_cnt=%0d expected 255", stall_cnt);
        end
    endtask

    task automatic test_reset_mid();
        logic [3:0] got, want;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            apply('{1, 0, 0, 0, 0, 6, 1, 0, 0, 0, 4'b1000, 'h40});
        end
        @(posedge clk);
        #1;
        checks++;
        if (pending_mask !== 8'h40 || busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid setup: mask=%h busy=%b expected 40 1", pending_mask, busy);
        end
        @(negedge clk);
        rst = 1'b0;
        apply('{1, 6, 1, 0, 0, 6, 1, 1, 6, 0, 4'b0000, 0});
        exp_q.push_back(4'b0000);
        exp_sc = 0;
        #1;
        got  = {issue_fire, stall, fwd_rs, fwd_rt};
        want = exp_q.pop_front();
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL reset_mid in_reset: fire/stall/fwd_rs/fwd_rt=%b expected %b", got, want);
        end
        @(posedge clk);
        #1;
        checks++;
        if (pending_mask !== 8'h00 || busy !== 1'b0 || stall_cnt !== 8'd0) begin
            errors++;
            $display("FAIL reset_mid cleared: mask=%h busy=%b stall_cnt=%0d expected 00 0 0",
                     pending_mask, busy, stall_cnt);
        end
        @(negedge clk);
        rst = 1'b1;
        wb_exempt = 1'b1;
        apply('{0, 0, 0, 0, 0, 0, 0, 1, 6, 0, 4'b0000, 0});
        @(posedge clk);
        #1;
        checks++;
        if (pending_mask !== 8'h00 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid stale_wb: mask=%h busy=%b expected 00 0", pending_mask, busy);
        end
        @(negedge clk);
        wb_exempt = 1'b0;
        apply('{1, 6, 1, 6, 1, 0, 0, 0, 0, 0, 4'b1000, 0});
        exp_q.push_back(4'b1000);
        #1;
        got  = {issue_fire, stall, fwd_rs, fwd_rt};
        want = exp_q.pop_front();
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL reset_mid reissue: fire/stall/fwd_rs/fwd_rt=%b expected %b", got, want);
        end
        @(negedge clk);
        apply('{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 0});
    endtask

    initial begin
        rst = 1'b0;
        apply('{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 0});
        test_reset();
        test_raw_forward();
        test_dest_full();
        test_same_cycle_wb();
        test_flush();
        test_stall_saturate();
        test_reset_mid();
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
